// File: rtl/ringbuf_ctrl_if.sv
// ringbuf_ctrl_if: ring buffer control bus; controls enable/flush/wr_req/rd_req in, wr_en/wr_ptr/ramadrs/outstrobe/count/full/empty/overflow/underflow out
interface ringbuf_ctrl_if #(parameter int counter_size = 4);
  logic enable;
  logic flush;
  logic wr_req;
  logic rd_req;
  logic wr_en;
  logic [counter_size-1:0] wr_ptr;
  logic [2*counter_size:0] ramadrs;
  logic outstrobe;
  logic [counter_size:0] count;
  logic full;
  logic empty;
  logic overflow;
  logic underflow;
  modport master (
    output enable, flush, wr_req, rd_req,
    input  wr_en, wr_ptr, ramadrs, outstrobe, count, full, empty, overflow, underflow
  );
  modport slave (
    input  enable, flush, wr_req, rd_req,
    output wr_en, wr_ptr, ramadrs, outstrobe, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/ringbuf_ctrl.sv
// ringbuf_ctrl: ring buffer pointer/flow controller; ports clock, reset (sync, active-high) and bus (ringbuf_ctrl_if.slave) carrying requests, pointers, address bus and status flags
module ringbuf_ctrl #(
  parameter int counter_size = 4,
  parameter int buffer_size  = 16
) (
  input logic clock,
  input logic reset,
  ringbuf_ctrl_if.slave bus
);
  localparam int cs = counter_size;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [cs:0] wptr, rptr, count, cnt_nxt;
  logic [cs-1:0] rd_addr;
  logic outstrobe, overflow, underflow;
  logic full, empty, rd_acc, wr_acc;
  assign full    = count == (cs+1)'(buffer_size);
  assign empty   = count == '0;
  assign rd_acc  = bus.rd_req & (state != IDLE) & !empty;
  assign wr_acc  = bus.wr_req & (state == RUN) & (!full | rd_acc);
  assign cnt_nxt = count + (cs+1)'(wr_acc) - (cs+1)'(rd_acc);
  assign bus.wr_en     = wr_acc;
  assign bus.wr_ptr    = wptr[cs-1:0];
  assign bus.ramadrs   = {wptr[cs] ^ rptr[cs], wptr[cs-1:0], rd_addr};
  assign bus.outstrobe = outstrobe;
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      rd_addr   <= '0;
      count     <= '0;
      outstrobe <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.flush) begin
      state     <= bus.enable ? RUN : IDLE;
      wptr      <= '0;
      rptr      <= '0;
      rd_addr   <= '0;
      count     <= '0;
      outstrobe <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= bus.enable ? RUN : (state != IDLE && cnt_nxt != '0) ? DRAIN : IDLE;
      wptr      <= wr_acc ? wptr + 1'b1 : wptr;
      rptr      <= rd_acc ? rptr + 1'b1 : rptr;
      rd_addr   <= rd_acc ? rptr[cs-1:0] : rd_addr;
      count     <= cnt_nxt;
      outstrobe <= rd_acc;
      overflow  <= overflow | (bus.wr_req & (state == RUN) & full & !rd_acc);
      underflow <= underflow | (bus.rd_req & (state != IDLE) & empty);
    end
  end
endmodule

// File: doc/ringbuf_ctrl.md
Name: ringbuf_ctrl

Overview:
Pointer and flow controller for the serial ring buffer. It accepts write requests from the transmit side and read requests from the receive side, and maintains the write and read pointers and the fill count. It drives the packed address bus into the bit-select readout, together with the `outstrobe` qualifier that gates `rxda`. It also drives the write enable for the storage array, and sequences enable, drain and flush of the buffer.

Parameters:
- counter_size, 4, pointer width in bits.
- buffer_size, 16, number of buffer entries. Must equal 2**counter_size; the pointers wrap naturally at this value.

Ports:
- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; sampled on the rising edge of `clock`.
- enable  input  1  level; 1 = run, 0 = stop accepting writes and drain.
- flush  input  1  single-cycle pulse; discard all buffered contents.
- wr_req  input  1  write one bit this cycle (transmit strobe).
- rd_req  input  1  read one bit.
- wr_en  output  1  combinational; storage writes at `wr_ptr` on this clock edge.
- wr_ptr  output  counter_size  current write pointer (registered).
- ramadrs  output  2*counter_size+1  packed address bus, fields:
  - [counter_size-1:0] = rd_addr
  - [2*counter_size-1:counter_size] = wr_ptr
  - [2*counter_size] = wrap phase, wptr_phase XOR rptr_phase
- outstrobe  output  1  registered; rd_addr is valid and rxda is qualified this cycle.
- count  output  counter_size+1  number of entries held, 0..buffer_size.
- full  output  1  count == buffer_size.
- empty  output  1  count == 0.
- overflow  output  1  sticky; a write was refused because the buffer was full.
- underflow  output  1  sticky; a read was refused because the buffer was empty.

Behaviour:
- Reset values, synchronous:
  - state = IDLE.
  - wptr, rptr, rd_addr and both phase bits = 0.
  - count = 0, outstrobe = 0, overflow = 0, underflow = 0.
  - Hence empty = 1, full = 0, wr_en = 0, ramadrs = 0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when enable = 1.
  - RUN -> DRAIN when enable = 0 and count != 0.
  - RUN -> IDLE when enable = 0 and count == 0.
  - DRAIN -> IDLE when count reaches 0 and no write is accepted.
  - DRAIN -> RUN if enable returns to 1.
- Write acceptance, combinational:
  - wr_acc = wr_req & (state == RUN) & (!full | rd_acc).
  - wr_en = wr_acc.
  - On the edge: wptr <= wptr + 1, with wptr_phase toggling on wrap from buffer_size-1 to 0.
- Read acceptance: rd_acc = rd_req & (state != IDLE) & !empty. On the edge:
  - rd_addr <= rptr.
  - rptr <= rptr + 1, with rptr_phase toggling on wrap.
  - outstrobe <= 1.
- outstrobe is 0 in every cycle that follows an edge without rd_acc.
- Read latency: one cycle. The request is sampled at edge N; rd_addr and outstrobe are valid during cycle N+1.
- Back-to-back reads give continuous outstrobe and increment rd_addr every cycle.
- Count update: count <= count + wr_acc - rd_acc. A simultaneous write and read leaves count unchanged, including when full.
- A write while full with no read is dropped: pointers unchanged, overflow <= 1.
- A read while empty is dropped: outstrobe <= 0, underflow <= 1.
- A write and read to an empty buffer in the same cycle: the read is refused (no bypass) and underflow is set.
- Sticky flags clear only on reset or flush.
- wr_req in IDLE or DRAIN is ignored silently; overflow is not set.
- rd_req in IDLE is ignored silently.
- flush, highest priority after reset:
  - Pointers, phases, count, rd_addr, outstrobe and sticky flags go to 0.
  - State -> RUN if enable = 1, else IDLE.
  - Writes and reads in the same cycle as flush are discarded.
- Reset mid-operation: all state returns to reset values on that edge regardless of other inputs.

Test Plan:
1. Reset, enable=1, write 3 bits, then 3 consecutive rd_req:
   - count goes 3→0.
   - outstrobe is high for 3 cycles, starting one cycle after the first rd_req.
   - rd_addr = 0, 1, 2; empty=1 at the end.
2. Fill with 16 writes, then a 17th write:
   - full=1, count=16.
   - 17th write: wr_en=0 and overflow=1.
   - wptr=0 with phase bit 1, so ramadrs[8]=1.
3. Full buffer, wr_req and rd_req together:
   - count stays 16, wr_en=1, wptr→1, rptr→1.
   - outstrobe high next cycle with rd_addr=0.
4. Empty buffer, rd_req=1 with wr_req=1 in the same cycle:
   - outstrobe=0 next cycle, underflow=1.
   - count=1 after the edge.
5. Write 5 bits, drop enable, issue wr_req and rd_req:
   - State goes to DRAIN; writes are ignored (wr_en=0).
   - 5 reads complete, then state = IDLE.
6. Write 7 bits, pulse flush with rd_req=1:
   - count=0, outstrobe=0 next cycle, flags clear, state stays RUN.
   - Repeat with reset asserted mid-read: all outputs return to 0 and empty=1.
